// File: rtl/requant_output_packer_pkg.sv
// requant_output_packer_pkg: shared widths, FSM state encodings and int8 saturation helper.
package requant_output_packer_pkg;
    localparam int PK_DATA_WIDTH = 8;
    localparam int PK_LANES = 8;
    localparam int PK_SRAM_WIDTH = PK_LANES * PK_DATA_WIDTH;
    localparam int PK_ADDR_WIDTH = 18;
    localparam logic signed [9:0] SAT_MIN = -10'sd128;
    localparam logic signed [9:0] SAT_MAX = 10'sd127;

    typedef enum logic [1:0] {PK_IDLE, PK_RUN, PK_FLUSH, PK_DONE} pk_state_t;

    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        return v < SAT_MIN ? SAT_MIN[7:0] : v > SAT_MAX ? SAT_MAX[7:0] : v[7:0];
    endfunction
endpackage

// File: rtl/requant_output_packer_if.sv
// requant_output_packer_if: input lane beat plus output-SRAM write port.
interface requant_output_packer_if import requant_output_packer_pkg::*; #(
    parameter int DATA_WIDTH = PK_DATA_WIDTH,
    parameter int LANES = PK_LANES,
    parameter int SRAM_WIDTH = PK_SRAM_WIDTH,
    parameter int MAX_ADDR_WIDTH = PK_ADDR_WIDTH
) ();
    logic in_valid;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic [3:0] in_num_lanes;
    logic sram_we;
    logic [MAX_ADDR_WIDTH-1:0] sram_addr;
    logic [SRAM_WIDTH-1:0] sram_wdata;
    logic [LANES-1:0] sram_wmask;

    modport master(output in_valid, in_data, in_num_lanes, input sram_we, sram_addr, sram_wdata, sram_wmask);
    modport slave(input in_valid, in_data, in_num_lanes, output sram_we, sram_addr, sram_wdata, sram_wmask);
endinterface

// File: rtl/requant_output_packer_byte_compactor.sv
// requant_output_packer_byte_compactor: appends lanes 0..n-1 at byte offset cnt of the 16-byte buffer.
module requant_output_packer_byte_compactor import requant_output_packer_pkg::*; #(
    parameter int DATA_WIDTH = PK_DATA_WIDTH,
    parameter int LANES = PK_LANES
) (
    input  logic [2*LANES*DATA_WIDTH-1:0] buf_in,
    input  logic [3:0] cnt,
    input  logic [LANES*DATA_WIDTH-1:0] data,
    input  logic [3:0] n,
    output logic [2*LANES*DATA_WIDTH-1:0] buf_out
);
    logic [LANES*DATA_WIDTH-1:0] masked;

    // Bytes at and above cnt are always zero in buf_in, so OR-ing is a safe append.
    always_comb begin
        masked = '0;
        for (int i = 0; i < LANES; i++)
            masked[i*DATA_WIDTH +: DATA_WIDTH] = i < int'(n) ? data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        buf_out = buf_in | ({{LANES*DATA_WIDTH{1'b0}}, masked} << (cnt * DATA_WIDTH));
    end
endmodule

// File: rtl/requant_output_packer.sv
// requant_output_packer: packs int8 lane beats into masked 64-bit SRAM words, flushes the tail, pulses done.
// Optional OUTPUT_OFFSET_EN adds a saturating signed output zero point to every accepted lane.
module requant_output_packer import requant_output_packer_pkg::*; #(
    parameter int DATA_WIDTH = PK_DATA_WIDTH,
    parameter int LANES = PK_LANES,
    parameter int SRAM_WIDTH = PK_SRAM_WIDTH,
    parameter int MAX_ADDR_WIDTH = PK_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [MAX_ADDR_WIDTH-1:0] base_addr,
    input  logic [MAX_ADDR_WIDTH-1:0] total_elems,
    requant_output_packer_if.slave bus,
    output logic busy,
    output logic done,
    output logic overflow_err
`ifdef OUTPUT_OFFSET_EN
    ,
    input  logic signed [7:0] output_offset
`endif
);
    localparam int W = MAX_ADDR_WIDTH;

    pk_state_t state, state_next;
    logic [2*SRAM_WIDTH-1:0] buf_q, merged;
    logic [LANES*DATA_WIDTH-1:0] lanes;
    logic [3:0] cnt, n, req;
    logic [4:0] fill;
    logic [W-1:0] elems, total, next_addr, remaining;
    logic accept, trunc, stray, last;

    always_comb begin
        req = bus.in_num_lanes > 4'(LANES) ? 4'(LANES) : bus.in_num_lanes;
        remaining = total - elems;
        trunc = W'(req) > remaining;
        n = trunc ? remaining[3:0] : req;
        accept = bus.in_valid && state == PK_RUN && !start;
        stray = bus.in_valid && state != PK_RUN && !start && req != 4'd0;
        last = accept && elems + W'(n) == total;
        fill = {1'b0, cnt} + {1'b0, n};
        state_next = start ? PK_RUN :
                     state == PK_RUN ? (last ? PK_FLUSH : PK_RUN) :
                     state == PK_FLUSH ? PK_DONE : PK_IDLE;
    end

`ifdef OUTPUT_OFFSET_EN
    always_comb begin
        lanes = '0;
        for (int i = 0; i < LANES; i++)
            lanes[i*8 +: 8] = sat8({{2{bus.in_data[i*8+7]}}, bus.in_data[i*8 +: 8]} + {{2{output_offset[7]}}, output_offset});
    end
`else
    assign lanes = bus.in_data;
`endif

    requant_output_packer_byte_compactor #(.DATA_WIDTH(DATA_WIDTH), .LANES(LANES)) u_compactor (
        .buf_in(buf_q),
        .cnt(cnt),
        .data(lanes),
        .n(n),
        .buf_out(merged)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= PK_IDLE;
        else state <= state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sram_we <= 1'b0;
            bus.sram_addr <= '0;
            bus.sram_wdata <= '0;
            bus.sram_wmask <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            overflow_err <= 1'b0;
            buf_q <= '0;
            cnt <= '0;
            elems <= '0;
            total <= '0;
            next_addr <= '0;
        end else begin
            bus.sram_we <= 1'b0;
            done <= 1'b0;
            busy <= state_next == PK_RUN || state_next == PK_FLUSH;
            if (start) begin
                buf_q <= '0;
                cnt <= '0;
                elems <= '0;
                total <= total_elems;
                next_addr <= base_addr;
                overflow_err <= 1'b0;
            end else begin
                if ((accept && trunc) || stray) overflow_err <= 1'b1;
                if (accept) begin
                    elems <= elems + W'(n);
                    if (fill >= 5'(LANES)) begin
                        bus.sram_we <= 1'b1;
                        bus.sram_addr <= next_addr;
                        bus.sram_wdata <= merged[SRAM_WIDTH-1:0];
                        bus.sram_wmask <= '1;
                        buf_q <= merged >> SRAM_WIDTH;
                        cnt <= 4'(fill - 5'(LANES));
                        next_addr <= next_addr + 1'b1;
                    end else begin
                        buf_q <= merged;
                        cnt <= fill[3:0];
                    end
                end
                if (state == PK_FLUSH) begin
                    done <= 1'b1;
                    buf_q <= '0;
                    cnt <= '0;
                    if (cnt != 4'd0) begin
                        bus.sram_we <= 1'b1;
                        bus.sram_addr <= next_addr;
                        bus.sram_wdata <= buf_q[SRAM_WIDTH-1:0];
                        bus.sram_wmask <= LANES'((1 << cnt) - 1);
                        next_addr <= next_addr + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_requant_output_packer.sv
// tb_requant_output_packer: directed and random beats against a byte-queue reference model.
module tb_requant_output_packer;
    import requant_output_packer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [17:0] base_addr = '0;
    logic [17:0] total_elems = '0;
    logic busy, done, overflow_err;
`ifdef OUTPUT_OFFSET_EN
    logic signed [7:0] off = '0;
`endif

    requant_output_packer_if bus ();

    requant_output_packer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .total_elems(total_elems),
        .bus(bus),
        .busy(busy),
        .done(done),
        .overflow_err(overflow_err)
`ifdef OUTPUT_OFFSET_EN
        ,
        .output_offset(off)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: accepted bytes queue up in order; every 8 form a word.
    int phase = 0;
    logic [7:0] q[$];
    logic [17:0] m_addr = '0;
    int m_total = 0;
    int m_elems = 0;
    logic exp_we = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
    logic [17:0] exp_addr = '0;
    logic [63:0] exp_data = '0;
    logic [7:0] exp_mask = '0;

    function automatic logic [7:0] msat(input logic [7:0] v, input int o);
        int s;
        s = int'($signed(v)) + o;
        s = s > 127 ? 127 : s < -128 ? -128 : s;
        return 8'(s);
    endfunction

    task automatic emit(input int k, input logic [7:0] m);
        exp_we = 1;
        exp_addr = m_addr;
        exp_data = '0;
        for (int i = 0; i < k; i++) exp_data[i*8 +: 8] = q.pop_front();
        exp_mask = m;
        m_addr = m_addr + 18'd1;
    endtask

    task automatic model_step();
        int req, rem, n;
        logic [7:0] b;
        exp_we = 0;
        exp_done = 0;
        req = bus.in_num_lanes > 8 ? 8 : int'(bus.in_num_lanes);
        if (start) begin
            phase = 1;
            q.delete();
            m_elems = 0;
            m_total = int'(total_elems);
            m_addr = base_addr;
            exp_err = 0;
        end else if (phase == 1) begin
            if (bus.in_valid) begin
                rem = m_total - m_elems;
                n = req < rem ? req : rem;
                if (req > rem) exp_err = 1;
                for (int i = 0; i < n; i++) begin
                    b = bus.in_data[i*8 +: 8];
`ifdef OUTPUT_OFFSET_EN
                    b = msat(b, int'(off));
`endif
                    q.push_back(b);
                end
                m_elems += n;
                if (q.size() >= 8) emit(8, 8'hFF);
                if (m_elems == m_total) phase = 2;
            end
        end else begin
            if (bus.in_valid && req > 0) exp_err = 1;
            if (phase == 2) begin
                if (q.size() > 0) emit(q.size(), 8'((1 << q.size()) - 1));
                exp_done = 1;
                phase = 3;
            end else if (phase == 3) phase = 0;
        end
        exp_busy = phase == 1 || phase == 2;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            q.delete();
            m_addr = '0;
            exp_we = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
            exp_addr = '0; exp_data = '0; exp_mask = '0;
        end else model_step();
    end

    logic [17:0] la[$];
    logic [63:0] ld[$];
    logic [7:0] lm[$];

    task automatic compare_all();
        chk("we", bus.sram_we, exp_we);
        chk("addr", bus.sram_addr, exp_addr);
        chk("wdata", bus.sram_wdata, exp_data);
        chk("wmask", bus.sram_wmask, exp_mask);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("overflow_err", overflow_err, exp_err);
        if (bus.sram_we) begin
            la.push_back(bus.sram_addr);
            ld.push_back(bus.sram_wdata);
            lm.push_back(bus.sram_wmask);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic go(input logic [17:0] base, input logic [17:0] total);
        la.delete(); ld.delete(); lm.delete();
        start = 1; base_addr = base; total_elems = total;
        tick();
        start = 0;
    endtask

    task automatic beat(input int nl, input logic [63:0] d);
        bus.in_valid = 1; bus.in_num_lanes = 4'(nl); bus.in_data = d;
        tick();
        bus.in_valid = 0; bus.in_num_lanes = '0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_num_lanes = '0; bus.in_data = '0;
        repeat (2) @(negedge clk);
        compare_all();
        rst = 0;
        tick();

        // two full beats
        go(18'h100, 18'd16);
        beat(8, 64'h1111111111111111);
        beat(8, 64'h2222222222222222);
        tick();
        chk("full_done", done, 1'b1);
        repeat (2) tick();
        chk("full_nwrites", la.size(), 2);
        if (la.size() == 2) begin
            chk("full_a0", la[0], 18'h100);
            chk("full_a1", la[1], 18'h101);
            chk("full_m0", lm[0], 8'hFF);
            chk("full_m1", lm[1], 8'hFF);
        end

        // mixed lane counts with partial tail
        go(18'h200, 18'd10);
        beat(3, 64'h0000000000030201);
        beat(7, 64'h000A090807060504);
        chk("mix_word", bus.sram_wdata, 64'h0807060504030201);
        chk("mix_addr", bus.sram_addr, 18'h200);
        tick();
        chk("mix_part", bus.sram_wdata, 64'h0000000000000A09);
        chk("mix_pmask", bus.sram_wmask, 8'h03);
        chk("mix_paddr", bus.sram_addr, 18'h201);
        chk("mix_done", done, 1'b1);
        repeat (2) tick();

        // truncated beat
        go(18'h300, 18'd5);
        beat(8, 64'h8877665544332211);
        chk("ovf_nofull", bus.sram_we, 1'b0);
        tick();
        chk("ovf_mask", bus.sram_wmask, 8'h1F);
        chk("ovf_err", overflow_err, 1'b1);
        tick();
        go(18'h380, 18'd8);
        chk("ovf_clear", overflow_err, 1'b0);

        // restart discards buffered bytes
        go(18'h400, 18'd20);
        beat(3, 64'h0000000000ABCDEF);
        go(18'h500, 18'd8);
        beat(8, 64'h0123456789ABCDEF);
        chk("rst_addr", bus.sram_addr, 18'h500);
        chk("rst_data", bus.sram_wdata, 64'h0123456789ABCDEF);
        repeat (3) tick();

`ifdef OUTPUT_OFFSET_EN
        off = 8'sd10;
        go(18'h600, 18'd3);
        beat(3, 64'h000000000080FB78);
        tick();
        chk("off_data", bus.sram_wdata, 64'h00000000008A057F);
        off = 8'sd0;
        repeat (2) tick();
`endif

        // async reset while flushing
        go(18'h700, 18'd5);
        beat(5, 64'h0000000504030201);
        #2 rst = 1;
        #1;
        chk("arst_we", bus.sram_we, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_addr", bus.sram_addr, 18'h0);
        chk("arst_data", bus.sram_wdata, 64'h0);
        @(negedge clk);
        rst = 0;
        repeat (3) tick();

        // random runs
        for (int r = 0; r < 40; r++) begin
`ifdef OUTPUT_OFFSET_EN
            off = 8'($urandom);
`endif
            go(($urandom % 4 == 0) ? 18'h3FFFC : 18'($urandom), 18'(1 + $urandom % 40));
            for (int c = 0; c < 50; c++) begin
                bus.in_valid = $urandom % 4 != 0;
                bus.in_num_lanes = 4'($urandom);
                bus.in_data = {$urandom, $urandom};
                if ($urandom % 60 == 0) begin
                    start = 1; base_addr = 18'($urandom); total_elems = 18'(1 + $urandom % 30);
                end
                tick();
                start = 0;
            end
            bus.in_valid = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
